// File: rtl/branch_history_queue.sv
// branch_history_queue: in-order queue of in-flight predicted branches.
// Three lanes allocate entries at the tail, three lanes resolve them by tag.
// Up to three consecutive resolved entries retire from the head each cycle
// and are presented, registered, to the gshare predictor update ports.
// A flush discards every entry younger than flush_tag_i.
// Optional feature: define BHQ_PERF_CNT_EN to build the branch and mispredict
// performance counters. Without it both perf outputs are tied to zero.
module branch_history_queue #(
  parameter int DEPTH      = 16,
  parameter int HIST_W     = 6,
  parameter int ADDR_WIDTH = 32,
  parameter int TAG_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alloc_valid_i_0,
  input  logic                  alloc_valid_i_1,
  input  logic                  alloc_valid_i_2,
  input  logic [ADDR_WIDTH-1:0] alloc_pc_i_0,
  input  logic [ADDR_WIDTH-1:0] alloc_pc_i_1,
  input  logic [ADDR_WIDTH-1:0] alloc_pc_i_2,
  input  logic [HIST_W-1:0]     alloc_hist_i_0,
  input  logic [HIST_W-1:0]     alloc_hist_i_1,
  input  logic [HIST_W-1:0]     alloc_hist_i_2,
  output logic [TAG_W-1:0]      alloc_tag_o_0,
  output logic [TAG_W-1:0]      alloc_tag_o_1,
  output logic [TAG_W-1:0]      alloc_tag_o_2,
  output logic                  alloc_ready_o,
  input  logic                  resolve_valid_i_0,
  input  logic                  resolve_valid_i_1,
  input  logic                  resolve_valid_i_2,
  input  logic [TAG_W-1:0]      resolve_tag_i_0,
  input  logic [TAG_W-1:0]      resolve_tag_i_1,
  input  logic [TAG_W-1:0]      resolve_tag_i_2,
  input  logic                  resolve_mispredict_i_0,
  input  logic                  resolve_mispredict_i_1,
  input  logic                  resolve_mispredict_i_2,
  input  logic                  flush_i,
  input  logic [TAG_W-1:0]      flush_tag_i,
  output logic                  update_valid_o_0,
  output logic                  update_valid_o_1,
  output logic                  update_valid_o_2,
  output logic [ADDR_WIDTH-1:0] update_pc_o_0,
  output logic [ADDR_WIDTH-1:0] update_pc_o_1,
  output logic [ADDR_WIDTH-1:0] update_pc_o_2,
  output logic [HIST_W-1:0]     update_hist_o_0,
  output logic [HIST_W-1:0]     update_hist_o_1,
  output logic [HIST_W-1:0]     update_hist_o_2,
  output logic                  update_mispredict_o_0,
  output logic                  update_mispredict_o_1,
  output logic                  update_mispredict_o_2,
  output logic [TAG_W:0]        count_o,
  output logic [31:0]           perf_branches_o,
  output logic [31:0]           perf_mispredicts_o
);

  localparam int LANES = 3;
  localparam logic [TAG_W:0] DEPTH_C = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0] LANES_C = (TAG_W+1)'(LANES);

  logic [TAG_W-1:0]      head_r;
  logic [TAG_W-1:0]      tail_r;
  logic [TAG_W:0]        count_r;
  logic [DEPTH-1:0]      done_r;
  logic [DEPTH-1:0]      misp_r;
  logic [ADDR_WIDTH-1:0] pc_mem_r   [DEPTH];
  logic [HIST_W-1:0]     hist_mem_r [DEPTH];

  logic                  upd_valid_r [LANES];
  logic [ADDR_WIDTH-1:0] upd_pc_r    [LANES];
  logic [HIST_W-1:0]     upd_hist_r  [LANES];
  logic                  upd_misp_r  [LANES];

  logic                  alloc_valid_s [LANES];
  logic [ADDR_WIDTH-1:0] alloc_pc_s    [LANES];
  logic [HIST_W-1:0]     alloc_hist_s  [LANES];
  logic [TAG_W-1:0]      alloc_tag_s   [LANES];
  logic                  res_valid_s   [LANES];
  logic [TAG_W-1:0]      res_tag_s     [LANES];
  logic                  res_misp_s    [LANES];
  logic                  res_ok_s      [LANES];

  logic                  alloc_ready_s;
  logic                  alloc_fire_s;
  logic [TAG_W:0]        alloc_n_s;
  logic [TAG_W:0]        kept_s;
  logic [TAG_W:0]        drain_lim_s;
  logic [TAG_W:0]        drain_n_s;
  logic                  drain_stop_s;

  assign alloc_valid_s[0] = alloc_valid_i_0;
  assign alloc_valid_s[1] = alloc_valid_i_1;
  assign alloc_valid_s[2] = alloc_valid_i_2;
  assign alloc_pc_s[0]    = alloc_pc_i_0;
  assign alloc_pc_s[1]    = alloc_pc_i_1;
  assign alloc_pc_s[2]    = alloc_pc_i_2;
  assign alloc_hist_s[0]  = alloc_hist_i_0;
  assign alloc_hist_s[1]  = alloc_hist_i_1;
  assign alloc_hist_s[2]  = alloc_hist_i_2;
  assign res_valid_s[0]   = resolve_valid_i_0;
  assign res_valid_s[1]   = resolve_valid_i_1;
  assign res_valid_s[2]   = resolve_valid_i_2;
  assign res_tag_s[0]     = resolve_tag_i_0;
  assign res_tag_s[1]     = resolve_tag_i_1;
  assign res_tag_s[2]     = resolve_tag_i_2;
  assign res_misp_s[0]    = resolve_mispredict_i_0;
  assign res_misp_s[1]    = resolve_mispredict_i_1;
  assign res_misp_s[2]    = resolve_mispredict_i_2;

  // Allocation needs room for a full group of three; a flush cancels it.
  assign alloc_ready_s = (count_r <= (DEPTH_C - LANES_C));
  assign alloc_fire_s  = alloc_ready_s & ~flush_i;
  // Entries surviving a flush: head through flush_tag_i inclusive.
  assign kept_s        = {1'b0, flush_tag_i - head_r} + (TAG_W+1)'(1);

  // Pack valid allocate lanes onto consecutive tags starting at the tail.
  always_comb begin
    alloc_n_s = '0;
    for (int k = 0; k < LANES; k++) begin
      alloc_tag_s[k] = tail_r + alloc_n_s[TAG_W-1:0];
      if (alloc_valid_s[k]) alloc_n_s = alloc_n_s + (TAG_W+1)'(1);
      else                  alloc_n_s = alloc_n_s;
    end
  end

  // A resolve only counts when its tag lies inside the occupied window.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      res_ok_s[k] = res_valid_s[k] & ({1'b0, res_tag_s[k] - head_r} < count_r);
    end
  end

  // Count consecutive done entries at the head, stopping at the first gap.
  always_comb begin
    if (flush_i) drain_lim_s = kept_s;
    else         drain_lim_s = count_r;
    drain_n_s    = '0;
    drain_stop_s = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (!drain_stop_s && ((TAG_W+1)'(k) < drain_lim_s) && done_r[head_r + TAG_W'(k)]) begin
        drain_n_s = drain_n_s + (TAG_W+1)'(1);
      end else begin
        drain_stop_s = 1'b1;
      end
    end
  end

  // Pointers, occupancy, per-entry status bits and registered update lanes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
      done_r  <= '0;
      misp_r  <= '0;
      for (int k = 0; k < LANES; k++) begin
        upd_valid_r[k] <= 1'b0;
        upd_pc_r[k]    <= '0;
        upd_hist_r[k]  <= '0;
        upd_misp_r[k]  <= 1'b0;
      end
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (res_ok_s[k]) begin
          done_r[res_tag_s[k]] <= 1'b1;
          misp_r[res_tag_s[k]] <= res_misp_s[k];
        end
      end
      for (int k = 0; k < LANES; k++) begin
        if ((TAG_W+1)'(k) < drain_n_s) begin
          done_r[head_r + TAG_W'(k)] <= 1'b0;
          upd_valid_r[k] <= 1'b1;
          upd_pc_r[k]    <= pc_mem_r[head_r + TAG_W'(k)];
          upd_hist_r[k]  <= hist_mem_r[head_r + TAG_W'(k)];
          upd_misp_r[k]  <= misp_r[head_r + TAG_W'(k)];
        end else begin
          upd_valid_r[k] <= 1'b0;
          upd_pc_r[k]    <= '0;
          upd_hist_r[k]  <= '0;
          upd_misp_r[k]  <= 1'b0;
        end
      end
      for (int k = 0; k < LANES; k++) begin
        if (alloc_fire_s && alloc_valid_s[k]) begin
          done_r[alloc_tag_s[k]] <= 1'b0;
          misp_r[alloc_tag_s[k]] <= 1'b0;
        end
      end
      head_r <= head_r + drain_n_s[TAG_W-1:0];
      if (flush_i) begin
        tail_r  <= flush_tag_i + TAG_W'(1);
        count_r <= kept_s - drain_n_s;
      end else if (alloc_fire_s) begin
        tail_r  <= tail_r + alloc_n_s[TAG_W-1:0];
        count_r <= count_r + alloc_n_s - drain_n_s;
      end else begin
        count_r <= count_r - drain_n_s;
      end
    end
  end

  // Payload storage; only entries inside the occupied window are ever read.
  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (alloc_fire_s && alloc_valid_s[k]) begin
        pc_mem_r[alloc_tag_s[k]]   <= alloc_pc_s[k];
        hist_mem_r[alloc_tag_s[k]] <= alloc_hist_s[k];
      end
    end
  end

`ifdef BHQ_PERF_CNT_EN
  logic [31:0] perf_br_r;
  logic [31:0] perf_mis_r;
  logic [31:0] drain_mis_s;

  // Number of retiring entries that were mispredicted.
  always_comb begin
    drain_mis_s = '0;
    for (int k = 0; k < LANES; k++) begin
      if (((TAG_W+1)'(k) < drain_n_s) && misp_r[head_r + TAG_W'(k)]) drain_mis_s = drain_mis_s + 32'd1;
      else                                                            drain_mis_s = drain_mis_s;
    end
  end

  // Free-running, wrapping retirement counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_br_r  <= 32'd0;
      perf_mis_r <= 32'd0;
    end else begin
      perf_br_r  <= perf_br_r + 32'(drain_n_s);
      perf_mis_r <= perf_mis_r + drain_mis_s;
    end
  end

  assign perf_branches_o    = perf_br_r;
  assign perf_mispredicts_o = perf_mis_r;
`else
  assign perf_branches_o    = 32'd0;
  assign perf_mispredicts_o = 32'd0;
`endif

  assign alloc_ready_o         = alloc_ready_s;
  assign alloc_tag_o_0         = alloc_tag_s[0];
  assign alloc_tag_o_1         = alloc_tag_s[1];
  assign alloc_tag_o_2         = alloc_tag_s[2];
  assign count_o               = count_r;
  assign update_valid_o_0      = upd_valid_r[0];
  assign update_valid_o_1      = upd_valid_r[1];
  assign update_valid_o_2      = upd_valid_r[2];
  assign update_pc_o_0         = upd_pc_r[0];
  assign update_pc_o_1         = upd_pc_r[1];
  assign update_pc_o_2         = upd_pc_r[2];
  assign update_hist_o_0       = upd_hist_r[0];
  assign update_hist_o_1       = upd_hist_r[1];
  assign update_hist_o_2       = upd_hist_r[2];
  assign update_mispredict_o_0 = upd_misp_r[0];
  assign update_mispredict_o_1 = upd_misp_r[1];
  assign update_mispredict_o_2 = upd_misp_r[2];

endmodule

// File: tb/tb_branch_history_queue.sv
// Directed bench for branch_history_queue. Expected retirements are queued
// when the resolves that cause them are issued; a negedge monitor pops one
// record per valid update lane and compares pc/hist/mispredict.
module tb_branch_history_queue;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        av [3];
  logic [31:0] apc [3];
  logic [5:0]  ah [3];
  logic [3:0]  atag [3];
  logic        alloc_ready;
  logic        rv [3];
  logic [3:0]  rt [3];
  logic        rm [3];
  logic        flush;
  logic [3:0]  ftag;
  logic        uv [3];
  logic [31:0] upc [3];
  logic [5:0]  uh [3];
  logic        um [3];
  logic [4:0]  count;
  logic [31:0] perf_br;
  logic [31:0] perf_mis;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_br   = 0;
  int exp_mis  = 0;
  logic [38:0] exp_q [$];

  branch_history_queue dut (
    .clk(clk), .reset(reset),
    .alloc_valid_i_0(av[0]), .alloc_valid_i_1(av[1]), .alloc_valid_i_2(av[2]),
    .alloc_pc_i_0(apc[0]), .alloc_pc_i_1(apc[1]), .alloc_pc_i_2(apc[2]),
    .alloc_hist_i_0(ah[0]), .alloc_hist_i_1(ah[1]), .alloc_hist_i_2(ah[2]),
    .alloc_tag_o_0(atag[0]), .alloc_tag_o_1(atag[1]), .alloc_tag_o_2(atag[2]),
    .alloc_ready_o(alloc_ready),
    .resolve_valid_i_0(rv[0]), .resolve_valid_i_1(rv[1]), .resolve_valid_i_2(rv[2]),
    .resolve_tag_i_0(rt[0]), .resolve_tag_i_1(rt[1]), .resolve_tag_i_2(rt[2]),
    .resolve_mispredict_i_0(rm[0]), .resolve_mispredict_i_1(rm[1]), .resolve_mispredict_i_2(rm[2]),
    .flush_i(flush), .flush_tag_i(ftag),
    .update_valid_o_0(uv[0]), .update_valid_o_1(uv[1]), .update_valid_o_2(uv[2]),
    .update_pc_o_0(upc[0]), .update_pc_o_1(upc[1]), .update_pc_o_2(upc[2]),
    .update_hist_o_0(uh[0]), .update_hist_o_1(uh[1]), .update_hist_o_2(uh[2]),
    .update_mispredict_o_0(um[0]), .update_mispredict_o_1(um[1]), .update_mispredict_o_2(um[2]),
    .count_o(count), .perf_branches_o(perf_br), .perf_mispredicts_o(perf_mis)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [5:0] h, input logic m);
    exp_q.push_back({pc, h, m});
    exp_br++;
    if (m) exp_mis++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 3; k++) begin
      av[k] = 1'b0; apc[k] = 32'd0; ah[k] = 6'd0;
      rv[k] = 1'b0; rt[k] = 4'd0; rm[k] = 1'b0;
    end
    flush = 1'b0;
    ftag  = 4'd0;
  endtask

  task automatic set_alloc(input logic [2:0] v, input logic [31:0] p0, input logic [31:0] p1,
                           input logic [31:0] p2, input logic [5:0] h0, input logic [5:0] h1,
                           input logic [5:0] h2);
    av[0] = v[0]; av[1] = v[1]; av[2] = v[2];
    apc[0] = p0; apc[1] = p1; apc[2] = p2;
    ah[0] = h0; ah[1] = h1; ah[2] = h2;
  endtask

  task automatic set_res(input logic [2:0] v, input logic [3:0] t0, input logic [3:0] t1,
                         input logic [3:0] t2, input logic m0, input logic m1, input logic m2);
    rv[0] = v[0]; rv[1] = v[1]; rv[2] = v[2];
    rt[0] = t0; rt[1] = t1; rt[2] = t2;
    rm[0] = m0; rm[1] = m1; rm[2] = m2;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    exp_br  = 0;
    exp_mis = 0;
    exp_q.delete();
  endtask

  // Scoreboard monitor: every valid update lane must match the next expectation.
  always @(negedge clk) begin
    logic [38:0] e;
    for (int k = 0; k < 3; k++) begin
      if (uv[k] === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_update lane %0d: actual pc %0h required no update", k, upc[k]);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("update_lane%0d", k), {25'd0, upc[k], uh[k], um[k]}, {25'd0, e});
        end
      end
    end
  end

  initial begin
    logic [2:0] v;
    clear_inputs();
    reset = 1'b0;
    #2;
    chk("reset_count", count, 5'd0);
    chk("reset_ready", alloc_ready, 1'b1);
    chk("reset_uvalid", {uv[0], uv[1], uv[2]}, 3'b000);
    chk("reset_perf", perf_br, 32'd0);
    reset = 1'b1;
    tick();

    // Scenario 1: out-of-order resolves, in-order drain of three.
    set_alloc(3'b111, 32'h100, 32'h104, 32'h108, 6'd1, 6'd2, 6'd3);
    #1;
    chk("s1_tag0", atag[0], 4'd0);
    chk("s1_tag1", atag[1], 4'd1);
    chk("s1_tag2", atag[2], 4'd2);
    tick(); clear_inputs();
    chk("s1_count3", count, 5'd3);
    set_res(3'b001, 4'd2, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    tick(); clear_inputs();
    chk("s1_nodrain_a", uv[0], 1'b0);
    set_res(3'b001, 4'd1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    tick(); clear_inputs();
    chk("s1_nodrain_b", uv[0], 1'b0);
    set_res(3'b001, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    push(32'h100, 6'd1, 1'b0);
    push(32'h104, 6'd2, 1'b0);
    push(32'h108, 6'd3, 1'b1);
    tick(); clear_inputs();
    chk("s1_nodrain_c", uv[0], 1'b0);
    tick();
    chk("s1_drain3", {uv[0], uv[1], uv[2]}, 3'b111);
    chk("s1_count0", count, 5'd0);
    tick();

    // Scenario 2a: ready drops once fewer than three entries are free.
    do_reset();
    tick();
    for (int i = 0; i < 4; i++) begin
      set_alloc(3'b111, 32'h1000, 32'h1004, 32'h1008, 6'd0, 6'd0, 6'd0);
      tick();
    end
    set_alloc(3'b011, 32'h1000, 32'h1004, 32'h1008, 6'd0, 6'd0, 6'd0);
    tick(); clear_inputs();
    chk("s2_count14", count, 5'd14);
    chk("s2_ready14", alloc_ready, 1'b0);
    set_alloc(3'b111, 32'h1000, 32'h1004, 32'h1008, 6'd0, 6'd0, 6'd0);
    tick(); clear_inputs();
    chk("s2_blocked14", count, 5'd14);

    // Scenario 2b: fill to exactly 16, no overwrite.
    do_reset();
    tick();
    for (int i = 0; i < 4; i++) begin
      set_alloc(3'b111, 32'h1100, 32'h1104, 32'h1108, 6'd0, 6'd0, 6'd0);
      tick();
    end
    set_alloc(3'b001, 32'h1100, 32'h0, 32'h0, 6'd0, 6'd0, 6'd0);
    tick(); clear_inputs();
    chk("s2_ready13", alloc_ready, 1'b1);
    set_alloc(3'b111, 32'h1200, 32'h1204, 32'h1208, 6'd0, 6'd0, 6'd0);
    tick(); clear_inputs();
    chk("s2_count16", count, 5'd16);
    chk("s2_ready16", alloc_ready, 1'b0);
    set_alloc(3'b111, 32'h1300, 32'h1304, 32'h1308, 6'd0, 6'd0, 6'd0);
    tick(); clear_inputs();
    chk("s2_full_hold", count, 5'd16);

    // Scenario 3: flush keeps tags 0..1 and drops the same-cycle allocation.
    do_reset();
    tick();
    set_alloc(3'b111, 32'h200, 32'h204, 32'h208, 6'd4, 6'd5, 6'd6);
    tick();
    set_alloc(3'b011, 32'h20c, 32'h210, 32'h0, 6'd8, 6'd9, 6'd0);
    tick(); clear_inputs();
    chk("s3_count5", count, 5'd5);
    set_alloc(3'b001, 32'hdead, 32'h0, 32'h0, 6'd63, 6'd0, 6'd0);
    flush = 1'b1;
    ftag  = 4'd1;
    tick(); clear_inputs();
    chk("s3_flush_count", count, 5'd2);
    set_alloc(3'b001, 32'h300, 32'h0, 32'h0, 6'd7, 6'd0, 6'd0);
    #1;
    chk("s3_next_tag", atag[0], 4'd2);
    tick(); clear_inputs();
    chk("s3_count3", count, 5'd3);
    set_res(3'b111, 4'd0, 4'd1, 4'd2, 1'b0, 1'b1, 1'b0);
    push(32'h200, 6'd4, 1'b0);
    push(32'h204, 6'd5, 1'b1);
    push(32'h300, 6'd7, 1'b0);
    tick(); clear_inputs();
    tick();
    chk("s3_drained", count, 5'd0);
    tick();

    // Scenario 4: move head to 14, then allocate across the wrap.
    do_reset();
    tick();
    for (int i = 0; i < 4; i++) begin
      set_alloc(3'b111, 32'h400 + 32'(12*i), 32'h404 + 32'(12*i), 32'h408 + 32'(12*i),
                6'(3*i), 6'(3*i+1), 6'(3*i+2));
      tick();
    end
    set_alloc(3'b011, 32'h430, 32'h434, 32'h0, 6'd12, 6'd13, 6'd0);
    tick(); clear_inputs();
    for (int c = 0; c < 5; c++) begin
      v = (c == 4) ? 3'b011 : 3'b111;
      set_res(v, 4'(3*c), 4'(3*c+1), 4'(3*c+2), 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
        if (v[k]) push(32'h400 + 32'(4*(3*c+k)), 6'(3*c+k), 1'b0);
      end
      tick(); clear_inputs();
    end
    tick(); tick();
    chk("s4_empty", count, 5'd0);
    set_alloc(3'b111, 32'ha00, 32'ha04, 32'ha08, 6'd10, 6'd11, 6'd12);
    #1;
    chk("s4_tag14", atag[0], 4'd14);
    chk("s4_tag15", atag[1], 4'd15);
    chk("s4_tag0", atag[2], 4'd0);
    tick(); clear_inputs();
    set_res(3'b111, 4'd14, 4'd15, 4'd0, 1'b0, 1'b1, 1'b0);
    push(32'ha00, 6'd10, 1'b0);
    push(32'ha04, 6'd11, 1'b1);
    push(32'ha08, 6'd12, 1'b0);
    tick(); clear_inputs();
    tick(); tick();
    chk("s4_count0", count, 5'd0);

    // Scenario 5: sparse lanes pack onto consecutive tags; perf counters.
    set_alloc(3'b101, 32'hb00, 32'h0, 32'hb08, 6'd20, 6'd0, 6'd22);
    #1;
    chk("s5_lane0_tag", atag[0], 4'd1);
    chk("s5_lane2_tag", atag[2], 4'd2);
    tick(); clear_inputs();
    set_alloc(3'b010, 32'h0, 32'hc04, 32'h0, 6'd0, 6'd21, 6'd0);
    #1;
    chk("s5_lane1_tag", atag[1], 4'd3);
    tick(); clear_inputs();
    chk("s5_count3", count, 5'd3);
    set_res(3'b111, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 1'b1);
    push(32'hb00, 6'd20, 1'b0);
    push(32'hb08, 6'd22, 1'b0);
    push(32'hc04, 6'd21, 1'b1);
    tick(); clear_inputs();
    tick(); tick();
`ifdef BHQ_PERF_CNT_EN
    chk("s5_perf_br", perf_br, 64'(exp_br));
    chk("s5_perf_mis", perf_mis, 64'(exp_mis));
`else
    chk("s5_perf_br_off", perf_br, 32'd0);
    chk("s5_perf_mis_off", perf_mis, 32'd0);
`endif

    // Scenario 6: asynchronous reset with seven entries pending.
    do_reset();
    tick();
    set_alloc(3'b111, 32'hd00, 32'hd04, 32'hd08, 6'd30, 6'd31, 6'd32);
    tick();
    set_alloc(3'b111, 32'hd0c, 32'hd10, 32'hd14, 6'd33, 6'd34, 6'd35);
    tick();
    set_alloc(3'b001, 32'hd18, 32'h0, 32'h0, 6'd36, 6'd0, 6'd0);
    tick(); clear_inputs();
    set_res(3'b001, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    push(32'hd00, 6'd30, 1'b0);
    tick(); clear_inputs();
    set_alloc(3'b001, 32'hd1c, 32'h0, 32'h0, 6'd37, 6'd0, 6'd0);
    tick(); clear_inputs();
    chk("s6_pre_valid", uv[0], 1'b1);
    chk("s6_pre_count", count, 5'd7);
    #6;
    reset = 1'b0;
    #1;
    chk("s6_rst_count", count, 5'd0);
    chk("s6_rst_uvalid", {uv[0], uv[1], uv[2]}, 3'b000);
    chk("s6_rst_upc", upc[0], 32'd0);
    chk("s6_rst_ready", alloc_ready, 1'b1);
    chk("s6_rst_perf", {perf_br, perf_mis}, 64'd0);
    reset   = 1'b1;
    exp_br  = 0;
    exp_mis = 0;
    tick();
    set_alloc(3'b001, 32'he00, 32'h0, 32'h0, 6'd1, 6'd0, 6'd0);
    #1;
    chk("s6_first_tag", atag[0], 4'd0);
    tick(); clear_inputs();
    chk("s6_count1", count, 5'd1);

    tick(); tick(); tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_history_queue.md
BRANCH_HISTORY_QUEUE -- requirements
Module: branch_history_queue

Interface
REQ-001 Parameters SHALL be:
- DEPTH, default 16; entry count, power of two.
- HIST_W, default 6; width of the predictor's global-history-plus-prediction field.
- ADDR_WIDTH, default 32; PC width.
- TAG_W = $clog2(DEPTH).
REQ-002 Clock and reset SHALL be: clk input 1, clock; reset input 1, asynchronous, active-low.
REQ-003 Allocate ports, k=0..2, SHALL be:
- alloc_valid_i_k input 1, allocate a predicted branch.
- alloc_pc_i_k input ADDR_WIDTH, branch PC.
- alloc_hist_i_k input HIST_W, history snapshot from fetch.
- alloc_tag_o_k output TAG_W, assigned entry tag.
REQ-004 alloc_ready_o output 1 SHALL be high when at least 3 entries are free.
REQ-005 Resolve ports, k=0..2, SHALL be:
- resolve_valid_i_k input 1, branch resolved.
- resolve_tag_i_k input TAG_W, tag of the resolved entry.
- resolve_mispredict_i_k input 1, prediction was wrong.
REQ-006 Flush ports SHALL be: flush_i input 1, discard younger entries; flush_tag_i input TAG_W, youngest entry kept.
REQ-007 Update ports, k=0..2, SHALL be: update_valid_o_k output 1; update_pc_o_k output ADDR_WIDTH; update_hist_o_k output HIST_W; update_mispredict_o_k output 1. These drive the gshare predictor update ports 0..2.
REQ-008 Status ports SHALL be: count_o output TAG_W+1, occupancy; perf_branches_o output 32; perf_mispredicts_o output 32.

Function
REQ-009 Storage SHALL be a circular buffer with head and tail pointers of TAG_W bits and a count register; pointers wrap modulo DEPTH.
REQ-010 Allocation SHALL occur only when alloc_ready_o=1.
- Valid lanes are packed in lane order: the first valid lane takes the tail, the next takes tail+1, and so on.
- alloc_tag_o_k is combinational and equals tail plus the number of valid lanes below k.
- On allocation the entry's done and mispredict bits SHALL be cleared.
REQ-011 A resolve SHALL set the entry's done bit and store resolve_mispredict_i_k. A resolve to an entry that is not allocated SHALL be ignored. Three resolves to distinct tags in one cycle SHALL all take effect.
REQ-012 Drain SHALL take up to 3 consecutive done entries starting at head, with no skipping past a not-done entry.
- Drained entries appear on update lanes 0..n-1, registered, in the cycle after the done bit is visible.
- Update outputs SHALL be registered; lanes not used SHALL have update_valid_o_k=0.
- Head advances and count decreases by n.
REQ-013 A resolve and a drain SHALL NOT drain the same entry in the same cycle; the drain sees done bits one cycle after the resolve.
REQ-014 On flush_i:
- tail <= flush_tag_i+1, and count is recomputed as ((flush_tag_i - head) mod DEPTH) + 1, minus the entries drained this cycle.
- Allocations in that cycle SHALL be dropped.
- Resolves and drain in that cycle to entries that are kept SHALL still take effect.
- flush_tag_i SHALL name an allocated entry; behaviour otherwise is undefined.
REQ-015 When allocation and drain happen in the same cycle, count SHALL change by alloc minus drain.
- A full queue SHALL never overwrite an entry.
- An empty queue SHALL produce no drain.
REQ-016 count_o SHALL equal the number of allocated, not-yet-drained entries at all times.

Reset
REQ-017 When reset is low:
- head, tail and count SHALL be 0, and all done bits 0.
- All update_valid_o_k SHALL be 0, and update_pc/hist/mispredict outputs 0.
- Perf counters SHALL be 0 and alloc_ready_o SHALL be 1.
REQ-018 Reset asserted mid-operation SHALL discard all entries immediately. The first allocation after release SHALL receive tag 0.

Configuration
REQ-019 Macro BHQ_PERF_CNT_EN:
- Defined: perf_branches_o SHALL increment by the number of drained entries per cycle. perf_mispredicts_o SHALL increment by the number of drained entries with the mispredict bit set. Both counters wrap at 2^32.
- Undefined: both outputs SHALL be constant 0 and no counter flops are built.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset, then allocate 3 lanes with PC 0x100/0x104/0x108 -> tags 0,1,2, count_o=3. Resolve tags 2,1,0 over three cycles -> no drain until tag 0 is done, then all 3 drain in one cycle in order.
- Fill 16 entries -> alloc_ready_o=0 at count 14. Further alloc_valid is ignored and count_o stays 16.
- Allocate 5 entries, flush_i with flush_tag_i=1 while lane 0 allocates -> count_o=2, the next allocated tag is 2, and the dropped allocation never appears.
- Wrap-around: head=14, allocate 3 -> tags 14,15,0. Resolve all -> drain order 14,15,0 with correct pc/hist.
- Lanes 0 and 2 valid, lane 1 idle -> tags t and t+1. With BHQ_PERF_CNT_EN, draining 3 entries with 1 mispredict -> perf_branches_o +3, perf_mispredicts_o +1.
- Reset asserted with 7 entries pending -> all outputs 0 and count_o=0 without a clock edge.
